// File: rtl/ascon_fsm.sv
// Sequencing controller for an ASCON-128 permutation datapath.
// Runs init, one AD block, G_NUM_PT_BLOCKS plaintext blocks, and finalisation.
module ascon_fsm #(
   parameter int G_NUM_PT_BLOCKS = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_start,
   input  logic       i_data_valid,
   output logic       o_data_ready,
   output logic       o_sys_enable,
   output logic       o_mux_select,
   output logic       o_enable_xor_key_begin,
   output logic       o_enable_xor_data_begin,
   output logic       o_enable_xor_key_end,
   output logic       o_enable_xor_lsb_end,
   output logic       o_enable_cipher_reg,
   output logic       o_enable_tag_reg,
   output logic       o_enable_state_reg,
   output logic [3:0] o_round,
   output logic [2:0] o_block_index,
   output logic       o_cipher_valid,
   output logic       o_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_AD_WAIT, S_AD_ROUND, S_PT_WAIT, S_PT_ROUND, S_FINAL, S_DONE
   } state_t;

   localparam logic [2:0] LAST_BLOCK = 3'(G_NUM_PT_BLOCKS - 1);
   localparam logic [3:0] LAST_ROUND = 4'd11;

   state_t     state_q, state_d;
   logic [3:0] counter_q, counter_d;
   logic [2:0] block_q, block_d;
   logic       cipher_valid_q, cipher_valid_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         counter_q      <= 4'd0;
         block_q        <= 3'd0;
         cipher_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         counter_q      <= counter_d;
         block_q        <= block_d;
         cipher_valid_q <= cipher_valid_d;
      end
   end

   assign o_cipher_valid = cipher_valid_q;

   always_comb begin
      state_d                 = state_q;
      counter_d               = counter_q;
      block_d                 = block_q;
      cipher_valid_d          = 1'b0;
      o_data_ready            = 1'b0;
      o_sys_enable            = 1'b0;
      o_mux_select            = 1'b0;
      o_enable_xor_key_begin  = 1'b0;
      o_enable_xor_data_begin = 1'b0;
      o_enable_xor_key_end    = 1'b0;
      o_enable_xor_lsb_end    = 1'b0;
      o_enable_cipher_reg     = 1'b0;
      o_enable_tag_reg        = 1'b0;
      o_enable_state_reg      = 1'b0;
      o_round                 = 4'd0;
      o_block_index           = 3'd0;
      o_done                  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d   = S_INIT;
               counter_d = 4'd0;
               block_d   = 3'd0;
            end
         end

         // Round 0 loads the fresh key/nonce state through the input side of the mux.
         S_INIT: begin
            o_sys_enable       = 1'b1;
            o_round            = counter_q;
            o_enable_state_reg = 1'b1;
            o_mux_select       = (counter_q != 4'd0);
            if (counter_q == LAST_ROUND) begin
               o_enable_xor_key_end = 1'b1;
               state_d              = S_AD_WAIT;
               counter_d            = 4'd0;
            end else begin
               counter_d = counter_q + 4'd1;
            end
         end

         S_AD_WAIT: begin
            o_sys_enable = 1'b1;
            o_data_ready = 1'b1;
            o_mux_select = 1'b1;
            if (i_data_valid) begin
               o_enable_xor_data_begin = 1'b1;
               o_round                 = 4'd6;
               o_enable_state_reg      = 1'b1;
               state_d                 = S_AD_ROUND;
               counter_d               = 4'd7;
            end
         end

         S_AD_ROUND: begin
            o_sys_enable       = 1'b1;
            o_mux_select       = 1'b1;
            o_enable_state_reg = 1'b1;
            o_round            = counter_q;
            if (counter_q == LAST_ROUND) begin
               o_enable_xor_lsb_end = 1'b1;
               state_d              = S_PT_WAIT;
               counter_d            = 4'd0;
               block_d              = 3'd0;
            end else begin
               counter_d = counter_q + 4'd1;
            end
         end

         // The last plaintext block folds straight into the 12-round finalisation.
         S_PT_WAIT: begin
            o_sys_enable  = 1'b1;
            o_data_ready  = 1'b1;
            o_mux_select  = 1'b1;
            o_block_index = block_q;
            if (i_data_valid) begin
               o_enable_xor_data_begin = 1'b1;
               o_enable_cipher_reg     = 1'b1;
               o_enable_state_reg      = 1'b1;
               cipher_valid_d          = 1'b1;
               if (block_q == LAST_BLOCK) begin
                  o_enable_xor_key_begin = 1'b1;
                  o_round                = 4'd0;
                  state_d                = S_FINAL;
                  counter_d              = 4'd1;
               end else begin
                  o_round   = 4'd6;
                  state_d   = S_PT_ROUND;
                  counter_d = 4'd7;
               end
            end
         end

         S_PT_ROUND: begin
            o_sys_enable       = 1'b1;
            o_mux_select       = 1'b1;
            o_enable_state_reg = 1'b1;
            o_round            = counter_q;
            o_block_index      = block_q;
            if (counter_q == LAST_ROUND) begin
               state_d   = S_PT_WAIT;
               counter_d = 4'd0;
               block_d   = block_q + 3'd1;
            end else begin
               counter_d = counter_q + 4'd1;
            end
         end

         S_FINAL: begin
            o_sys_enable       = 1'b1;
            o_mux_select       = 1'b1;
            o_enable_state_reg = 1'b1;
            o_round            = counter_q;
            o_block_index      = block_q;
            if (counter_q == LAST_ROUND) begin
               o_enable_xor_key_end = 1'b1;
               o_enable_tag_reg     = 1'b1;
               state_d              = S_DONE;
               counter_d            = 4'd0;
            end else begin
               counter_d = counter_q + 4'd1;
            end
         end

         S_DONE: begin
            o_sys_enable = 1'b1;
            o_done       = 1'b1;
            if (i_start) begin
               state_d   = S_INIT;
               counter_d = 4'd0;
               block_d   = 3'd0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/ascon_fsm.md
ASCON_FSM -- requirements
Module: ascon_fsm

Interface
REQ-001 SHALL have parameter G_NUM_PT_BLOCKS, default 4, meaning number of 64-bit plaintext blocks per message (legal range 1..8).
REQ-002 SHALL have port clock  input  1  system clock, rising-edge active.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  start request, sampled only in IDLE or DONE.
REQ-005 SHALL have port i_data_valid  input  1  AD/plaintext block present on the datapath i_data.
REQ-006 SHALL have port o_data_ready  output  1  controller can accept a block this cycle.
REQ-007 SHALL have ports o_sys_enable, o_mux_select, o_enable_xor_key_begin, o_enable_xor_data_begin, o_enable_xor_key_end, o_enable_xor_lsb_end, o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg  output  1 each  permutation datapath controls.
REQ-008 SHALL have port o_round  output  4  round-constant index for the datapath.
REQ-009 SHALL have port o_block_index  output  3  index of the plaintext block awaited or being processed.
REQ-010 SHALL have ports o_cipher_valid (1-cycle pulse, cipher register updated) and o_done (tag register valid)  output  1 each.

Function
REQ-011 SHALL implement states IDLE, INIT, AD_WAIT, AD_ROUND, PT_WAIT, PT_ROUND, FINAL, DONE with a registered 4-bit round counter.
REQ-012 SHALL drive o_sys_enable=0 in IDLE only, 1 in all other states; all other control outputs 0 unless stated below.
REQ-013 IDLE: i_start=1 -> INIT with counter=0; else stay.
REQ-014 INIT: o_round=counter (0..11), o_enable_state_reg=1, o_mux_select=0 at counter=0 and 1 otherwise; counter=11 also asserts o_enable_xor_key_end and goes to AD_WAIT.
REQ-015 AD_WAIT: o_data_ready=1, o_mux_select=1; i_data_valid=0 -> stay, no state update; i_data_valid=1 -> same cycle o_enable_xor_data_begin=1, o_round=6, o_enable_state_reg=1, go to AD_ROUND with counter=7.
REQ-016 AD_ROUND: o_mux_select=1, o_enable_state_reg=1, o_round=counter (7..11); counter=11 asserts o_enable_xor_lsb_end and goes to PT_WAIT with block index 0.
REQ-017 PT_WAIT: o_data_ready=1, o_mux_select=1; on i_data_valid=1 same cycle assert o_enable_xor_data_begin and o_enable_cipher_reg.
REQ-018 PT_WAIT accept, block index < G_NUM_PT_BLOCKS-1: o_round=6, o_enable_state_reg=1 -> PT_ROUND counter=7; PT_ROUND rounds 7..11 then PT_WAIT with block index +1.
REQ-019 PT_WAIT accept, block index = G_NUM_PT_BLOCKS-1: also assert o_enable_xor_key_begin, o_round=0, o_enable_state_reg=1 -> FINAL counter=1.
REQ-020 FINAL: o_mux_select=1, o_enable_state_reg=1, o_round=counter (1..11); counter=11 asserts o_enable_xor_key_end and o_enable_tag_reg and goes to DONE.
REQ-021 DONE: o_done=1, no enables (registers hold); i_start=1 -> INIT counter=0, o_done drops next cycle.
REQ-022 o_cipher_valid SHALL be registered, high exactly the cycle after each PT_WAIT accept.
REQ-023 i_start SHALL be ignored in INIT, AD_*, PT_*, FINAL; i_data_valid ignored outside *_WAIT states.
REQ-024 Latency with i_data_valid held 1: start edge to o_done = 12 + 6 + 6*(G_NUM_PT_BLOCKS-1) + 12 + 1 cycles.
REQ-025 o_block_index SHALL be 0 outside PT_WAIT/PT_ROUND/FINAL.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE, counter=0, block index=0, and every output 0, including mid-operation; first i_start after release begins a fresh INIT.

Verification
REQ-027 Reset: assert reset_n=0 any state -> all outputs 0, state IDLE, o_sys_enable=0.
REQ-028 Full run, default parameter, i_data_valid=1: i_start at edge 0 -> AD accepted cycle 13, o_cipher_valid at cycles 20,26,32,38, o_done=1 at cycle 49; with datapath attached, tag matches ASCON-128 known-answer vector.
REQ-029 Stall: hold i_data_valid=0 for 5 cycles in PT_WAIT block 1 -> o_enable_state_reg=0, o_round stable, o_done delayed exactly 5 cycles.
REQ-030 Ignored start: pulse i_start during INIT counter=5 and FINAL -> no state change, cycle counts unchanged.
REQ-031 G_NUM_PT_BLOCKS=1: first PT accept asserts xor_data_begin, xor_key_begin, cipher_reg together, o_round=0; o_done at cycle 31.
REQ-032 Reset mid-FINAL then restart -> o_done low during reset, fresh run completes with same tag as REQ-028.
